seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: accepts a WIDTH-bit pattern plus repeat count over a valid/ready

---
 rtl/seq_pattern_tx.sv | 117 +++++++++++
 tb/tb_seq_pattern_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: loads a WIDTH-bit pattern and repeat count, shifts it out MSB-first.
// Optional inter-repetition idle gap enabled by defining SEQ_TX_GAP_EN (length GAP_CYCLES).
module seq_pattern_tx #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  localparam bit GAP_ON = (GAP_CYCLES > 0);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  logic [GW-1:0] gap_q, gap_n;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [CNT_W-1:0] reps_q, reps_n;

  assign load_ready = (state_q == IDLE);

  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    idx_n   = idx_q;
    reps_n  = reps_q;
`ifdef SEQ_TX_GAP_EN
    gap_n   = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_n = SHIFT;
          pat_n   = pattern;
          idx_n   = LAST;
          reps_n  = rep_cnt;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_n = idx_q - IW'(1);
        end else if (reps_q == '0) begin
          state_n = DONE;
        end else begin
          // reps_left only decrements when nonzero, so rep_cnt of all-ones never wraps
          reps_n = reps_q - CNT_W'(1);
          idx_n  = LAST;
`ifdef SEQ_TX_GAP_EN
          if (GAP_ON) begin
            state_n = GAP;
            gap_n   = '0;
          end
`endif
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        if (gap_q == GAP_LAST) state_n = SHIFT;
        else                   gap_n   = gap_q + GW'(1);
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      pat_q   <= pat_n;
      idx_q   <= idx_n;
      reps_q  <= reps_n;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= gap_n;
`endif
    end
  end

  // Outputs are registered from the next state so the first bit appears right after the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      x       <= (state_n == SHIFT) ? pat_n[idx_n] : 1'b0;
      x_valid <= (state_n == SHIFT);
      done    <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: driver pushes per-cycle expected outputs, monitor compares.
module tb_seq_pattern_tx;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int GC = 2;
`ifdef SEQ_TX_GAP_EN
  localparam int GAP = GC;
`else
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  pattern = '0;
  logic [CW-1:0] rep_cnt = '0;
  logic          x, x_valid, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] expq[$];   // {done, x_valid, x} expected per cycle
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .rep_cnt(rep_cnt), .x(x), .x_valid(x_valid), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each repetition is the pattern MSB-first, gaps between reps, then one done cycle.
  function automatic void model(input logic [W-1:0] p, input int rep);
    for (int r = 0; r <= rep; r++) begin
      for (int i = W - 1; i >= 0; i--) expq.push_back({2'b01, p[i]});
      if (r < rep) for (int g = 0; g < GAP; g++) expq.push_back(3'b000);
    end
    expq.push_back(3'b100);
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      logic [2:0] e;
      e = (expq.size() > 0) ? expq.pop_front() : 3'b000;
      check("stream", int'({done, x_valid, x}), int'(e));
    end
  end

  task automatic handshake(input logic [W-1:0] p, input int rep);
    int k = 0;
    @(negedge clk);
    while (!load_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_load", int'(load_ready), 1);
    load_valid = 1'b1;
    pattern    = p;
    rep_cnt    = CW'(rep);
    @(posedge clk);
    #1;
    model(p, rep);
    check("ready_drop", int'(load_ready), 0);
  endtask

  task automatic finish(input bit noise, input int rep);
    int bound = (rep + 1) * (W + GAP) + 8;
    int k = 0;
    if (!noise) load_valid = 1'b0;
    @(negedge clk);
    while (!load_ready && k < bound) begin
      if (noise) begin
        load_valid = 1'($urandom_range(0, 1));
        pattern    = W'($urandom);
        rep_cnt    = CW'($urandom);
      end
      @(negedge clk);
      k++;
    end
    load_valid = 1'b0;
    check("done_in_time", int'(load_ready), 1);
    check("queue_drained", expq.size(), 0);
  endtask

  initial begin
    logic [W-1:0] p;
    int r;
    int k;
    #12;
    check("reset_state", int'({load_ready, done, x_valid, x}), 4'b1000);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    handshake(4'b1101, 0); finish(1'b0, 0);
    handshake(4'b1101, 2); finish(1'b0, 2);
    handshake(4'b1101, 2); finish(1'b1, 2);

    // abort during the second bit
    handshake(4'b1101, 0);
    load_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_outputs", int'({load_ready, done, x_valid, x}), 4'b1000);
    expq.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    handshake(4'b1101, 1); finish(1'b0, 1);

    // back-to-back with load_valid held high
    handshake(4'b1001, 0);
    pattern = 4'b0110;
    rep_cnt = '0;
    k = 0;
    @(negedge clk);
    while (!load_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_ready", int'(load_ready), 1);
    @(posedge clk);
    #1;
    model(4'b0110, 0);
    check("b2b_accept", int'(load_ready), 0);
    finish(1'b0, 0);

    handshake(4'b1010, 255); finish(1'b0, 255);

    repeat (25) begin
      p = W'($urandom);
      r = $urandom_range(0, 5);
      handshake(p, r);
      finish(1'($urandom_range(0, 1)), r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
